// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and code-table entry type for the Huffman bit packer.
//   NSYM    number of legal symbols (gray values 1..NSYM)
//   DW      width of gray_data, HCn, Mn and out_byte
//   MAXLEN  longest code length in bits
//   ACC_W   bit-accumulator width
//   CNT_W   width of the packed-bit counter
package huffman_pkg;

  localparam int unsigned NSYM   = 6;
  localparam int unsigned DW     = 8;
  localparam int unsigned MAXLEN = 7;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LEN_W  = 3;
  // fill never exceeds 7 + MAXLEN = 14, so 5 bits is enough
  localparam int unsigned FILL_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  typedef struct packed {
    logic [MAXLEN-1:0] code;
    logic [LEN_W-1:0]  len;
  } code_entry_t;

  // Code length is the popcount of the low-aligned mask, clipped to MAXLEN.
  function automatic logic [LEN_W-1:0] mask_len(input logic [DW-1:0] mask);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < DW; i++) begin
      cnt = cnt + 32'(mask[i]);
    end
    if (cnt > MAXLEN) cnt = MAXLEN;
    return cnt[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Registered symbol code table with combinational lookup.
//   clk, rst_n   clock and synchronous active-low reset (clears the table)
//   load         capture codes/masks this cycle
//   codes        NSYM right-aligned codes, entry 0 = symbol 1
//   masks        NSYM low-aligned masks; popcount gives the code length
//   sym          symbol to look up
//   entry        {code, len} for sym (zero when illegal)
//   illegal      sym is 0 or greater than NSYM
module huffman_code_lut
  import huffman_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [NSYM-1:0][DW-1:0]   codes,
  input  logic [NSYM-1:0][DW-1:0]   masks,
  input  logic [DW-1:0]             sym,
  output code_entry_t               entry,
  output logic                      illegal
);

  code_entry_t lut_q [NSYM];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) lut_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NSYM; i++) begin
        // Mask the code so stray bits above the code length never reach the accumulator
        lut_q[i].code <= MAXLEN'(codes[i] & masks[i]);
        lut_q[i].len  <= mask_len(masks[i]);
      end
    end
  end

  always_comb begin
    entry   = '0;
    illegal = 1'b1;
    for (int i = 0; i < NSYM; i++) begin
      if (sym == DW'(i + 1)) begin
        entry   = lut_q[i];
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/huffman_bitpacker.sv
// Packs per-pixel variable-length Huffman codes MSB-first into bytes.
//   clk, rst_n          clock, synchronous active-low reset
//   code_valid          table load pulse (honoured only when idle)
//   HC1..HC6, M1..M6    per-symbol code and low-aligned mask
//   in_valid/in_ready   pixel handshake; in_last marks the final pixel
//   gray_data           pixel symbol
//   out_valid/out_ready byte handshake
//   out_byte            packed bits, bit 7 first
//   out_nbits           valid bits in out_byte, left-aligned
//   out_last            final byte of the image
//   bit_cnt             saturating count of code bits packed since table load
//   err_sym             sticky illegal-symbol flag
//   done                one-cycle pulse after the last byte handshake
module huffman_bitpacker
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             code_valid,
  input  logic [DW-1:0]    HC1,
  input  logic [DW-1:0]    HC2,
  input  logic [DW-1:0]    HC3,
  input  logic [DW-1:0]    HC4,
  input  logic [DW-1:0]    HC5,
  input  logic [DW-1:0]    HC6,
  input  logic [DW-1:0]    M1,
  input  logic [DW-1:0]    M2,
  input  logic [DW-1:0]    M3,
  input  logic [DW-1:0]    M4,
  input  logic [DW-1:0]    M5,
  input  logic [DW-1:0]    M6,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [DW-1:0]    gray_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_byte,
  output logic [3:0]       out_nbits,
  output logic             out_last,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             err_sym,
  output logic             done
);

  localparam logic [FILL_W-1:0] ByteBits = FILL_W'(8);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                err_sym_q, err_sym_d;
  logic                out_valid_q, out_valid_d;
  logic [DW-1:0]       out_byte_q, out_byte_d;
  logic [3:0]          out_nbits_q, out_nbits_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;

  logic [NSYM-1:0][DW-1:0] codes, masks;
  code_entry_t             lut_entry;
  logic                    lut_illegal;
  logic                    load, accept, pop;
  logic [FILL_W-1:0]       pop_amt;
  logic [LEN_W-1:0]        push_len;
  logic [CNT_W:0]          bit_sum;

  assign codes = {HC6, HC5, HC4, HC3, HC2, HC1};
  assign masks = {M6, M5, M4, M3, M2, M1};
  assign load  = code_valid && (state_q == StIdle);

  huffman_code_lut u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .codes   (codes),
    .masks   (masks),
    .sym     (gray_data),
    .entry   (lut_entry),
    .illegal (lut_illegal)
  );

  assign in_ready = (state_q == StRun) && (fill_q < ByteBits);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;
  assign pop_amt  = !pop ? '0 : ((fill_q >= ByteBits) ? ByteBits : fill_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    err_sym_d = err_sym_q;
    push_len  = '0;
    bit_sum   = {1'b0, bit_cnt_q} + {{(CNT_W + 1 - LEN_W){1'b0}}, lut_entry.len};

    if (accept) begin
      if (lut_illegal) begin
        err_sym_d = 1'b1;
      end else begin
        push_len  = lut_entry.len;
        acc_d     = (acc_q << lut_entry.len) | ACC_W'(lut_entry.code);
        bit_cnt_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
    end
    // Push and pop may coincide; both apply
    fill_d = fill_q + FILL_W'(push_len) - pop_amt;

    unique case (state_q)
      StIdle: begin
        if (code_valid) begin
          state_d   = StRun;
          acc_d     = '0;
          fill_d    = '0;
          bit_cnt_d = '0;
          err_sym_d = 1'b0;
        end
      end
      StRun: begin
        if (accept && in_last) state_d = StFlush;
      end
      StFlush: begin
        if (pop && out_last_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage is computed from next-state so a byte appears one cycle after the push that
  // completed it, and holds naturally while stalled (no push or pop changes acc/fill).
  always_comb begin
    out_valid_d = (fill_d >= ByteBits) ||
                  ((state_d == StFlush) && ((fill_d != '0) || (bit_cnt_d == '0)));
    out_byte_d  = '0;
    out_nbits_d = '0;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      // Oldest live bit is acc[fill-1]; shifting {acc, 8'h00} right by fill left-aligns it
      // at bit 7 and zero-pads a short final byte.
      out_byte_d  = DW'({acc_d, 8'h00} >> fill_d);
      out_nbits_d = (fill_d >= ByteBits) ? 4'd8 : fill_d[3:0];
      out_last_d  = (state_d == StFlush) && (fill_d <= ByteBits);
    end
    done_d = (state_q == StFlush) && pop && out_last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      fill_q      <= '0;
      bit_cnt_q   <= '0;
      err_sym_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      bit_cnt_q   <= bit_cnt_d;
      err_sym_q   <= err_sym_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_nbits = out_nbits_q;
  assign out_last  = out_last_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_sym   = err_sym_q;
  assign done      = done_q;

endmodule

// File: tb/tb_huffman_bitpacker.sv
// Self-checking bench for huffman_bitpacker: a bit-queue model turns each pixel list into the
// expected byte sequence; a negedge compare process checks every output handshake against it.
module tb_huffman_bitpacker;

  logic        clk = 1'b0;
  logic        rst_n, code_valid, in_valid, in_last, in_ready;
  logic        out_valid, out_ready, out_last, err_sym, done;
  logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6;
  logic [7:0]  gray_data, out_byte;
  logic [3:0]  out_nbits;
  logic [15:0] bit_cnt;

  always #5 clk = ~clk;

  huffman_bitpacker dut (
    .clk (clk), .rst_n (rst_n), .code_valid (code_valid),
    .HC1 (HC1), .HC2 (HC2), .HC3 (HC3), .HC4 (HC4), .HC5 (HC5), .HC6 (HC6),
    .M1 (M1), .M2 (M2), .M3 (M3), .M4 (M4), .M5 (M5), .M6 (M6),
    .in_valid (in_valid), .in_last (in_last), .gray_data (gray_data), .in_ready (in_ready),
    .out_valid (out_valid), .out_ready (out_ready), .out_byte (out_byte),
    .out_nbits (out_nbits), .out_last (out_last), .bit_cnt (bit_cnt),
    .err_sym (err_sym), .done (done)
  );

  typedef struct {
    logic [7:0] b;
    int         n;
    bit         last;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ref_len  [7] = '{0, 1, 2, 3, 4, 5, 5};
  int         ref_code [7] = '{0, 0, 2, 6, 14, 30, 31};
  logic [7:0] stim[$];
  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] got_b[$];
  int         got_n[$];
  int         exp_bits;
  bit         exp_err;
  bit         chk_en = 1'b0;
  bit         held = 1'b0;
  logic [7:0] held_b;
  logic [3:0] held_n;
  int         stall_block = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Expected bytes from the code table rules: concatenate codes MSB-first, cut into bytes.
  task automatic model();
    bit bits[$];
    exp_t x;
    int   n;
    exp_q.delete();
    exp_bits = 0;
    exp_err  = 1'b0;
    foreach (stim[i]) begin
      if (stim[i] >= 1 && stim[i] <= 6) begin
        for (int k = ref_len[stim[i]] - 1; k >= 0; k--) bits.push_back(ref_code[stim[i]][k]);
        exp_bits += ref_len[stim[i]];
      end else begin
        exp_err = 1'b1;
      end
    end
    if (bits.size() == 0) begin
      x.b = 8'h00; x.n = 0; x.last = 1'b1;
      exp_q.push_back(x);
    end
    while (bits.size() > 0) begin
      n   = (bits.size() < 8) ? bits.size() : 8;
      x.b = 8'h00;
      for (int k = 0; k < n; k++) x.b[7-k] = bits.pop_front();
      x.n    = n;
      x.last = (bits.size() == 0);
      exp_q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid) check("in_ready_low_while_byte_pending", {31'd0, in_ready}, 32'd0);
      if (held) begin
        check("hold_byte", {24'd0, out_byte}, {24'd0, held_b});
        check("hold_nbits", {28'd0, out_nbits}, {28'd0, held_n});
      end
      if (in_valid && !in_ready && out_valid && !out_ready && !out_last) stall_block++;
      if (out_valid && out_ready) begin
        got_b.push_back(out_byte);
        got_n.push_back(int'(out_nbits));
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_byte: got %0h nbits %0d expected no byte", out_byte, out_nbits);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", {24'd0, out_byte}, {24'd0, e.b});
          check("out_nbits", {28'd0, out_nbits}, e.n);
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      held   = out_valid && !out_ready;
      held_b = out_byte;
      held_n = out_nbits;
    end else begin
      held = 1'b0;
    end
  end

  task automatic set_table(input bit alt);
    if (!alt) begin
      HC1 = 8'd0;  M1 = 8'd1;   HC2 = 8'd2;  M2 = 8'd3;   HC3 = 8'd6;  M3 = 8'd7;
      HC4 = 8'd14; M4 = 8'd15;  HC5 = 8'd30; M5 = 8'd31;  HC6 = 8'd31; M6 = 8'd31;
    end else begin
      HC1 = 8'd31; M1 = 8'd31;  HC2 = 8'd1;  M2 = 8'd1;   HC3 = 8'd0;  M3 = 8'd1;
      HC4 = 8'd1;  M4 = 8'd1;   HC5 = 8'd0;  M5 = 8'd3;   HC6 = 8'd0;  M6 = 8'd1;
    end
  endtask

  task automatic load_table(input bit alt);
    set_table(alt);
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic drive_stream();
    bit a;
    int guard;
    for (int i = 0; i < stim.size(); i++) begin
      in_valid  = 1'b1;
      gray_data = stim[i];
      in_last   = (i == stim.size() - 1);
      guard     = 0;
      do begin
        @(negedge clk);
        a = in_ready;
        @(posedge clk); #1;
        guard++;
      end while (!a && guard < 200);
      if (!a) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0 for 200 cycles expected acceptance");
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_image();
    bit seen = 1'b0;
    int guard = 0;
    while (guard < 300) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      guard++;
    end
    check("done_pulse", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("idle_after_done", {31'd0, out_valid}, 32'd0);
      check("bytes_remaining", exp_q.size(), 32'd0);
      check("bit_cnt", {16'd0, bit_cnt}, exp_bits);
      check("err_sym", {31'd0, err_sym}, {31'd0, exp_err});
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_first_case_bytes(input string tag);
    check({tag, "_nbytes"}, got_b.size(), 32'd2);
    if (got_b.size() == 2) begin
      check({tag, "_byte0"}, {24'd0, got_b[0]}, 32'hB3);
      check({tag, "_nbits0"}, got_n[0], 32'd8);
      check({tag, "_byte1"}, {24'd0, got_b[1]}, 32'hE0);
      check({tag, "_nbits1"}, got_n[1], 32'd3);
    end
  endtask

  task automatic first_case_stim();
    stim = '{8'd2, 8'd3, 8'd1, 8'd6};
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected bench completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; code_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0; gray_data = 8'd0;
    out_ready = 1'b1;
    set_table(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_byte", {24'd0, out_byte}, 32'd0);
    check("rst_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Case 1: 2,3,1,6 -> B3/8, E0/3 last; also pins the model
    first_case_stim();
    model();
    check("model_first_nbytes", exp_q.size(), 32'd2);
    check("model_first_b0", {24'd0, exp_q[0].b}, 32'hB3);
    check("model_first_b1", {24'd0, exp_q[1].b}, 32'hE0);
    check("model_first_n1", exp_q[1].n, 32'd3);
    got_b.delete(); got_n.delete();
    chk_en = 1'b1;
    load_table(1'b0);
    drive_stream();
    finish_image();
    check_first_case_bytes("case1");
    check("case1_bit_cnt_literal", {16'd0, bit_cnt}, 32'd11);

    // Case 2: eight 1s -> exactly one 0x00 byte, 8 bits, last
    stim = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    model();
    check("model_ones_nbytes", exp_q.size(), 32'd1);
    got_b.delete(); got_n.delete();
    load_table(1'b0);
    drive_stream();
    finish_image();
    check("ones_nbytes", got_b.size(), 32'd1);
    if (got_b.size() == 1) begin
      check("ones_byte", {24'd0, got_b[0]}, 32'h00);
      check("ones_nbits", got_n[0], 32'd8);
    end

    // Case 3: longer stream with a 10-cycle output stall mid-stream
    stim = '{8'd2, 8'd3, 8'd1, 8'd6, 8'd2, 8'd3, 8'd1, 8'd6, 8'd2, 8'd3, 8'd1, 8'd6};
    model();
    stall_block = 0;
    load_table(1'b0);
    fork
      drive_stream();
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    finish_image();
    check("in_ready_drops_on_stall", {31'd0, stall_block > 0}, 32'd1);

    // Case 4: illegal symbols 0 and 7 are swallowed but flagged
    stim = '{8'd0, 8'd2, 8'd3, 8'd7, 8'd1, 8'd6};
    model();
    got_b.delete(); got_n.delete();
    load_table(1'b0);
    drive_stream();
    finish_image();
    check_first_case_bytes("illegal");
    check("illegal_err_literal", {31'd0, err_sym}, 32'd1);

    // Case 5: reset in the middle of RUN aborts everything
    chk_en = 1'b0;
    load_table(1'b0);
    in_valid = 1'b1; in_last = 1'b0;
    gray_data = 8'd0;
    @(posedge clk); #1;
    gray_data = 8'd6;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_byte", {24'd0, out_byte}, 32'd0);
    check("midrst_out_nbits", {28'd0, out_nbits}, 32'd0);
    check("midrst_out_last", {31'd0, out_last}, 32'd0);
    check("midrst_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    check("midrst_err_sym", {31'd0, err_sym}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    first_case_stim();
    model();
    got_b.delete(); got_n.delete();
    chk_en = 1'b1;
    load_table(1'b0);
    drive_stream();
    finish_image();
    check_first_case_bytes("after_rst");

    // Case 6: a new table offered during RUN must be ignored
    first_case_stim();
    model();
    got_b.delete(); got_n.delete();
    load_table(1'b0);
    fork
      drive_stream();
      begin
        @(posedge clk); #1;
        set_table(1'b1);
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
      end
    join
    finish_image();
    check_first_case_bytes("cv_in_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
